// File: rtl/ad9226_acq_ctrl_if.sv
// AXI-Stream sample channel from the AD9226 acquisition controller to the
// DMA/FIFO path. The controller drives the master side.
interface ad9226_acq_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ad9226_acq_ctrl.sv
// AD9226 acquisition controller/sequencer.
// Generates the ADC sample clock, discards pipeline warm-up samples, converts
// offset-binary codes to sign-extended two's complement and emits AXI-Stream
// frames with TLAST.
// Optional build macro AD9226_ACQ_DROP_CNT_EN adds a saturating drop_count port.
// Reset is synchronous and active low.
module ad9226_acq_ctrl #(
  parameter int ADC_DATA_WIDTH  = 12,
  parameter int AXIS_DATA_WIDTH = 16,
  parameter int DIV_WIDTH       = 8,
  parameter int WARMUP_SAMPLES  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DIV_WIDTH-1:0]      cfg_div,
  input  logic [15:0]               cfg_frame_len,
  input  logic                      cfg_continuous,
  input  logic                      start,
  input  logic                      stop,
  output logic                      adc_clk,
  input  logic [ADC_DATA_WIDTH-1:0] adc_data,
  ad9226_acq_ctrl_if.master         m_axis,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow
`ifdef AD9226_ACQ_DROP_CNT_EN
  ,
  output logic [15:0]               drop_count
`endif
);

  localparam int WARM_W = (WARMUP_SAMPLES > 1) ? $clog2(WARMUP_SAMPLES) : 1;

  typedef enum logic [1:0] {IDLE, WARMUP, RUN, FLUSH} state_t;

  state_t state_q, state_d;

  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_sel;
  logic [DIV_WIDTH-1:0] div_eff;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [15:0]          frame_len_q;
  logic [15:0]          len_m1;
  logic [15:0]          frame_cnt;
  logic [15:0]          idx_next;
  logic                 cont_q;
  logic [WARM_W-1:0]    warm_cnt;
  logic                 adc_tgl;
  logic                 sample_ev;
  logic                 hs;
  logic                 last_hs;
  logic                 load;
  logic                 drop;
  logic                 done_d;

  logic signed [ADC_DATA_WIDTH-1:0] code_s;

  // IDLE follows the live divider so the ADC keeps a clock; a run uses the latched one.
  assign div_sel   = (state_q == IDLE) ? cfg_div : div_q;
  assign div_eff   = (div_sel < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_sel;
  // >= rather than == so a live divider shrinking below the count cannot stall the clock.
  assign adc_tgl   = (div_cnt >= div_eff - DIV_WIDTH'(1));
  assign sample_ev = adc_tgl && !adc_clk;

  assign hs      = m_axis.tvalid && m_axis.tready;
  assign last_hs = hs && m_axis.tlast;

  // Beat index of a sample loaded this cycle: the counter only moves on handshake,
  // so a handshake on the same edge already accounts for the outgoing beat.
  assign len_m1   = (frame_len_q == 16'd0) ? 16'd0 : frame_len_q - 16'd1;
  assign idx_next = !hs ? frame_cnt : (m_axis.tlast ? 16'd0 : frame_cnt + 16'd1);

  // Offset binary to two's complement is just an MSB inversion.
  assign code_s = {~adc_data[ADC_DATA_WIDTH-1], adc_data[ADC_DATA_WIDTH-2:0]};

  assign busy = (state_q != IDLE);

  // Next-state and per-cycle control decisions.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
    state_d = state_q;
    load    = 1'b0;
    drop    = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) state_d = (WARMUP_SAMPLES == 0) ? RUN : WARMUP;
      end
      WARMUP: begin
        if (stop) begin
          state_d = IDLE;
        end else if (sample_ev && (warm_cnt == WARM_W'(WARMUP_SAMPLES - 1))) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = FLUSH;
        end else begin
          if (last_hs) begin
            done_d = 1'b1;
            if (!cont_q) state_d = IDLE;
          end
          // A single frame is complete once its TLAST beat leaves; nothing more is captured.
          if (sample_ev && !(last_hs && !cont_q)) begin
            if (m_axis.tvalid && !m_axis.tready) drop = 1'b1;
            else                                 load = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (!m_axis.tvalid || hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, sample clock, configuration latch, counters and the AXIS output register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q       <= IDLE;
      adc_clk       <= 1'b0;
      div_cnt       <= '0;
      div_q         <= '0;
      frame_len_q   <= '0;
      cont_q        <= 1'b0;
      warm_cnt      <= '0;
      frame_cnt     <= '0;
      m_axis.tdata  <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tlast  <= 1'b0;
      done          <= 1'b0;
      overflow      <= 1'b0;
`ifdef AD9226_ACQ_DROP_CNT_EN
      drop_count    <= '0;
`endif
    end else begin
      state_q <= state_d;
      done    <= done_d;

      if (adc_tgl) begin
        adc_clk <= ~adc_clk;
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_WIDTH'(1);
      end

      if (state_q == IDLE && state_d != IDLE) begin
        div_q       <= cfg_div;
        frame_len_q <= cfg_frame_len;
        cont_q      <= cfg_continuous;
        warm_cnt    <= '0;
        frame_cnt   <= '0;
        overflow    <= 1'b0;
`ifdef AD9226_ACQ_DROP_CNT_EN
        drop_count  <= '0;
`endif
      end

      if (state_q == WARMUP && sample_ev) warm_cnt <= warm_cnt + WARM_W'(1);
      if (state_q == RUN) frame_cnt <= idx_next;

      if (hs) begin
        m_axis.tvalid <= 1'b0;
        m_axis.tlast  <= 1'b0;
      end
      if (load) begin
        m_axis.tdata  <= AXIS_DATA_WIDTH'(code_s);
        m_axis.tvalid <= 1'b1;
        m_axis.tlast  <= (idx_next == len_m1);
      end

      if (drop) begin
        overflow <= 1'b1;
`ifdef AD9226_ACQ_DROP_CNT_EN
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
`endif
      end
    end
  end

endmodule
